argsort_seq: RTL and testbench
==============================

ARGSORT_SEQ -- requirements
Module: argsort_seq

Interface
REQ-001 SHALL have parameter N, default 9, number of elements per frame (N >= 1).
REQ-002 SHALL have parameter W, default 8, element width in bits.
REQ-003 SHALL have parameter PW, default 4, pointer width, with 2^PW >= N.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port descend  input  1  sort direction: 0 ascending, 1 descending; sampled at the first accepted element of a frame.
REQ-006 SHALL have port in_valid  input  1  input element valid.
REQ-007 SHALL have port in_data  input  W  input element, unsigned.
REQ-008 SHALL have port in_ready  output  1  block accepts an element.
REQ-009 SHALL have port out_valid  output  1  sorted element available.
REQ-010 SHALL have port out_data  output  W  sorted element value.
REQ-011 SHALL have port out_ptr  output  PW  original 0-based arrival index of out_data.
REQ-012 SHALL have port out_last  output  1  marks the Nth output of a frame.
REQ-013 SHALL have port out_ready  input  1  consumer accepts an output.
REQ-014 SHALL have port busy  output  1  high in SORT and OUT states.

Function
REQ-015 SHALL implement FSM states LOAD, SORT and OUT.
REQ-016 In LOAD: in_ready = 1; each cycle with in_valid && in_ready stores the pair {in_data, idx}, with idx counting 0..N-1.
REQ-017 The accept of element N-1 SHALL transition the FSM to SORT on the next edge, with in_ready = 0 from that cycle.
REQ-018 In SORT: odd-even transposition over N passes, exactly N cycles; cycle k compares pairs (i, i+1) with i even when k is even and i odd when k is odd.
REQ-019 Ascending swap condition: a.val > b.val, or a.val == b.val and a.idx > b.idx.
REQ-020 Descending swap condition: a.val < b.val, or a.val == b.val and a.idx > b.idx.
REQ-021 Ties SHALL always be ordered by ascending original index, in both directions (stable sort).
REQ-022 After the Nth SORT cycle the FSM SHALL enter OUT.
REQ-023 In OUT: out_valid = 1; out_data/out_ptr present sorted position j, j = 0..N-1; j advances only on out_valid && out_ready.
REQ-024 While out_ready = 0, out_data, out_ptr and out_last SHALL hold stable.
REQ-025 out_last = 1 only when j = N-1.
REQ-026 The handshake with out_last SHALL return the FSM to LOAD on the next edge with in_ready = 1; no bubble beyond that edge.
REQ-027 Latency, last input accept to first out_valid: N+1 cycles.
REQ-028 in_valid outside LOAD SHALL be ignored and no data lost or captured.
REQ-029 The descend value SHALL be latched on the first accept (idx = 0) of a frame; later toggles within the frame have no effect.
REQ-030 N = 1: the SORT state lasts 1 cycle without a swap; the output is {in_data, 0} with out_last = 1.
REQ-031 All comparisons SHALL be unsigned over W bits; pointers SHALL be zero-extended to PW.

Reset
REQ-032 rst = 1 at a clock edge SHALL force LOAD and clear the element counter, output index and latched descend, in any state including mid-SORT and mid-OUT; the partial frame is discarded.
REQ-033 Reset output values SHALL be: in_ready = 0 while rst is high, then 1 on the cycle after rst is released; out_valid = 0, out_last = 0, busy = 0, out_data = 0, out_ptr = 0.
REQ-034 Storage array contents need not be cleared; they are overwritten on load.

Verification
REQ-035 Ascending, N=9, W=8: in 3,1,4,1,5,9,2,6,5 -> out_data 1,1,2,3,4,5,5,6,9; out_ptr 1,3,6,0,2,4,8,7,5; out_last on 9th only.
REQ-036 Descending, same input -> out_data 9,6,5,5,4,3,2,1,1; out_ptr 5,7,4,8,2,0,6,1,3.
REQ-037 All-equal input 7 x9, ascending and descending -> out_ptr 0..8 in order; max value 255 x9 gives the same result.
REQ-038 Backpressure: out_ready random 50% -> identical sequence as REQ-035; outputs stable while stalled; in_valid pulses during SORT/OUT ignored.
REQ-039 rst asserted in the 4th SORT cycle -> next cycle LOAD, busy=0, out_valid=0; the following frame 8,0,... sorts correctly with pointers starting at 0.
REQ-040 Back-to-back frames with descend toggled after element 0 -> the first frame uses the latched direction; the second frame is accepted the cycle after the out_last handshake; latency = N+1 cycles checked.

Source files
------------

// File: rtl/argsort_seq.sv
// Frame argsort: loads N elements, odd-even transposition sort over N cycles, then streams {value, arrival index}.
// Latency N+1 cycles from last accept to first out_valid; out_ready low freezes the output, in_ready is low outside LOAD.
module argsort_seq #(
    parameter int N  = 9,
    parameter int W  = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          descend,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [PW-1:0] out_ptr,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy
);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  j;
    logic           desc_r;
    logic [W-1:0]   vals      [N];
    logic [PW-1:0]  idxs      [N];
    logic [W-1:0]   sort_vals [N];
    logic [PW-1:0]  sort_idxs [N];
    logic [W-1:0]   sel_val;
    logic [PW-1:0]  sel_idx;
    logic           accept;
    logic           last_cnt;

    assign in_ready = (state == LOAD) && !rst;
    assign accept   = in_valid && in_ready;
    assign last_cnt = (cnt == CW'(N - 1));

    // Equal values always keep arrival order, whichever direction is sorted.
    function automatic logic swap_needed(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic [PW-1:0] ai, input logic [PW-1:0] bi,
                                         input logic desc);
        if (av == bv)
            return ai > bi;
        return desc ? (av < bv) : (av > bv);
    endfunction

    // One transposition pass; pass parity selects even or odd pairs.
    always_comb begin
        sort_vals = vals;
        sort_idxs = idxs;
        for (int i = 0; i < N - 1; i++) begin
            if (((i % 2) == 1) == cnt[0] &&
                swap_needed(vals[i], vals[i+1], idxs[i], idxs[i+1], desc_r)) begin
                sort_vals[i]   = vals[i+1];
                sort_vals[i+1] = vals[i];
                sort_idxs[i]   = idxs[i+1];
                sort_idxs[i+1] = idxs[i];
            end
        end
    end

    always_comb begin
        sel_val = '0;
        sel_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (j + CW'(1) == CW'(k)) begin
                sel_val = vals[k];
                sel_idx = idxs[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                if (cnt == CW'(i)) begin
                    vals[i] <= in_data;
                    idxs[i] <= PW'(i);
                end
            end
        end else if (state == SORT) begin
            vals <= sort_vals;
            idxs <= sort_idxs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            j         <= '0;
            desc_r    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_ptr   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (cnt == '0)
                            desc_r <= descend;
                        if (last_cnt) begin
                            state <= SORT;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                SORT: begin
                    if (last_cnt) begin
                        // Present position 0 straight from the final pass result.
                        state     <= OUT;
                        cnt       <= '0;
                        j         <= '0;
                        out_valid <= 1'b1;
                        out_data  <= sort_vals[0];
                        out_ptr   <= sort_idxs[0];
                        out_last  <= (N == 1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= LOAD;
                            j         <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            out_data  <= '0;
                            out_ptr   <= '0;
                        end else begin
                            j        <= j + CW'(1);
                            out_data <= sel_val;
                            out_ptr  <= sel_idx;
                            out_last <= (j + CW'(1) == CW'(N - 1));
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_argsort_seq.sv
// Randomized bench for argsort_seq (N=9 main instance plus an N=1 instance) against a rank-based stable-sort model.
module tb_argsort_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       descend;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] out_ptr;
    logic       out_last;
    logic       out_ready;
    logic       busy;

    logic       in_valid1;
    logic [7:0] in_data1;
    logic       in_ready1;
    logic       out_valid1;
    logic [7:0] out_data1;
    logic [0:0] out_ptr1;
    logic       out_last1;
    logic       out_ready1;
    logic       busy1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    argsort_seq #(.N(9), .W(8), .PW(4)) dut (
        .clk(clk), .rst(rst), .descend(descend), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ptr(out_ptr),
        .out_last(out_last), .out_ready(out_ready), .busy(busy)
    );

    argsort_seq #(.N(1), .W(8), .PW(1)) dut1 (
        .clk(clk), .rst(rst), .descend(descend), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1), .out_ptr(out_ptr1),
        .out_last(out_last1), .out_ready(out_ready1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Final position of each element = number of elements that must precede it.
    task automatic model(input logic [7:0] v[9], input logic d,
                         output logic [7:0] ed[9], output logic [3:0] ep[9]);
        for (int a = 0; a < 9; a++) begin
            int rank;
            rank = 0;
            for (int b = 0; b < 9; b++) begin
                if (b != a && ((d ? v[b] > v[a] : v[b] < v[a]) || (v[b] == v[a] && b < a)))
                    rank++;
            end
            ed[rank] = v[a];
            ep[rank] = 4'(a);
        end
    endtask

    task automatic send_frame(input logic [7:0] v[9], input logic d, input bit toggle,
                              output int first_acc, output int last_acc, output int to);
        to = 0;
        first_acc = -1;
        last_acc = -1;
        for (int i = 0; i < 9; i++) begin
            int g;
            g = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = v[i];
                descend  = (toggle && i > 0) ? ~d : d;
                g++;
            end while (!in_ready && g < 60);
            if (!in_ready) begin
                to = 1;
                break;
            end
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int pct, input bit poke,
                           output logic [7:0] d[9], output logic [3:0] p[9], output logic l[9],
                           output int first_v, output int hs, output int bad, output int to);
        int j;
        int g;
        logic held;
        logic [7:0] pd;
        logic [3:0] pp;
        logic pl;
        j = 0; g = 0; held = 0; bad = 0; first_v = -1; hs = -1;
        pd = '0; pp = '0; pl = 1'b0;
        while (j < 9 && g < 400) begin
            @(negedge clk);
            g++;
            out_ready = ($urandom_range(99) < pct);
            in_valid  = poke ? 1'($urandom_range(1)) : 1'b0;
            in_data   = 8'($urandom);
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (held && (out_data !== pd || out_ptr !== pp || out_last !== pl)) bad++;
                if (out_ready) begin
                    d[j] = out_data; p[j] = out_ptr; l[j] = out_last;
                    hs = cyc;
                    j++;
                    held = 0;
                end else begin
                    held = 1; pd = out_data; pp = out_ptr; pl = out_last;
                end
            end
        end
        to = (j < 9) ? 1 : 0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_last, busy, out_data, out_ptr} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b busy=%b data=%0d ptr=%0d, want all 0",
                     in_ready, out_valid, out_last, busy, out_data, out_ptr);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b in_ready1=%b, want 1 1", in_ready, in_ready1);
        end
    endtask

    task automatic test_fixed(input logic d, input int pct, input bit poke);
        logic [7:0] v[9] = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
        logic [7:0] ad[9] = '{1, 1, 2, 3, 4, 5, 5, 6, 9};
        logic [3:0] ap[9] = '{1, 3, 6, 0, 2, 4, 8, 7, 5};
        logic [7:0] dd[9] = '{9, 6, 5, 5, 4, 3, 2, 1, 1};
        logic [3:0] dp[9] = '{5, 7, 4, 8, 2, 0, 6, 1, 3};
        logic [7:0] gd[9];
        logic [3:0] gp[9];
        logic gl[9];
        int fa, la, fv, hs, bad, to1, to2;
        send_frame(v, d, 1'b0, fa, la, to1);
        collect(pct, poke, gd, gp, gl, fv, hs, bad, to2);
        checks++;
        if (to1 != 0 || to2 != 0) begin
            errors++;
            $display("FAIL fixed_timeout: got send=%0d collect=%0d, want 0 0", to1, to2);
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (gd[k] !== (d ? dd[k] : ad[k]) || gp[k] !== (d ? dp[k] : ap[k]) || gl[k] !== (k == 8)) begin
                    errors++;
                    $display("FAIL fixed desc=%0b pos %0d: got data=%0d ptr=%0d last=%b, want data=%0d ptr=%0d last=%b",
                             d, k, gd[k], gp[k], gl[k], d ? dd[k] : ad[k], d ? dp[k] : ap[k], k == 8);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_stable: got %0d changes while stalled, want 0", bad);
        end
    endtask

    task automatic test_all_equal;
        logic [7:0] v[9];
        logic [7:0] gd[9];
        logic [3:0] gp[9];
        logic gl[9];
        int fa, la, fv, hs, bad, to1, to2;
        for (int t = 0; t < 4; t++) begin
            logic [7:0] c;
            c = (t < 2) ? 8'd7 : 8'd255;
            for (int i = 0; i < 9; i++) v[i] = c;
            send_frame(v, 1'(t % 2), 1'b0, fa, la, to1);
            collect(100, 1'b0, gd, gp, gl, fv, hs, bad, to2);
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (to1 != 0 || to2 != 0 || gd[k] !== c || gp[k] !== 4'(k) || gl[k] !== (k == 8)) begin
                    errors++;
                    $display("FAIL all_equal t=%0d pos %0d: got data=%0d ptr=%0d last=%b to=%0d/%0d, want data=%0d ptr=%0d",
                             t, k, gd[k], gp[k], gl[k], to1, to2, c, k);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] v[9];
        logic [7:0] ed[9];
        logic [3:0] ep[9];
        logic [7:0] gd[9];
        logic [3:0] gp[9];
        logic gl[9];
        logic d;
        int fa, la, fv, hs, bad, to1, to2;
        for (int t = 0; t < 6; t++) begin
            d = 1'($urandom_range(1));
            for (int i = 0; i < 9; i++)
                v[i] = (t % 2 == 0) ? 8'($urandom_range(3)) : 8'($urandom);
            model(v, d, ed, ep);
            send_frame(v, d, 1'b0, fa, la, to1);
            collect(70, 1'b1, gd, gp, gl, fv, hs, bad, to2);
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (to1 != 0 || to2 != 0 || gd[k] !== ed[k] || gp[k] !== ep[k] || gl[k] !== (k == 8)) begin
                    errors++;
                    $display("FAIL random t=%0d pos %0d: got data=%0d ptr=%0d last=%b, want data=%0d ptr=%0d",
                             t, k, gd[k], gp[k], gl[k], ed[k], ep[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_sort;
        logic [7:0] v[9];
        logic [7:0] ed[9];
        logic [3:0] ep[9];
        logic [7:0] gd[9];
        logic [3:0] gp[9];
        logic gl[9];
        int fa, la, fv, hs, bad, to1, to2;
        for (int i = 0; i < 9; i++) v[i] = 8'($urandom);
        send_frame(v, 1'b1, 1'b0, fa, la, to1);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || cyc - la != 4) begin
            errors++;
            $display("FAIL mid_sort_busy: got busy=%b at cycle offset %0d, want busy=1 at 4", busy, cyc - la);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_sort_reset: got busy=%b out_valid=%b, want 0 0", busy, out_valid);
        end
        rst = 1'b0;
        v[0] = 8'd8;
        v[1] = 8'd0;
        for (int i = 2; i < 9; i++) v[i] = 8'($urandom);
        model(v, 1'b0, ed, ep);
        send_frame(v, 1'b0, 1'b0, fa, la, to1);
        collect(100, 1'b0, gd, gp, gl, fv, hs, bad, to2);
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (to1 != 0 || to2 != 0 || gd[k] !== ed[k] || gp[k] !== ep[k] || gl[k] !== (k == 8)) begin
                errors++;
                $display("FAIL after_reset pos %0d: got data=%0d ptr=%0d last=%b, want data=%0d ptr=%0d",
                         k, gd[k], gp[k], gl[k], ed[k], ep[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] v[9];
        logic [7:0] ed[9];
        logic [3:0] ep[9];
        logic [7:0] gd[9];
        logic [3:0] gp[9];
        logic gl[9];
        int fa, la, fv, hs, bad, to1, to2, prev_hs;
        prev_hs = -1;
        for (int f = 0; f < 2; f++) begin
            logic d;
            d = (f == 0) ? 1'b1 : 1'b0;
            for (int i = 0; i < 9; i++) v[i] = 8'($urandom_range(15));
            model(v, d, ed, ep);
            send_frame(v, d, 1'b1, fa, la, to1);
            if (f == 1) begin
                checks++;
                if (fa - prev_hs != 1) begin
                    errors++;
                    $display("FAIL b2b_accept: got first accept %0d cycles after handshake, want 1", fa - prev_hs);
                end
            end
            collect(100, 1'b0, gd, gp, gl, fv, hs, bad, to2);
            prev_hs = hs;
            checks++;
            if (fv - la != 10) begin
                errors++;
                $display("FAIL latency f=%0d: got %0d cycles, want 10", f, fv - la);
            end
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (to1 != 0 || to2 != 0 || gd[k] !== ed[k] || gp[k] !== ep[k] || gl[k] !== (k == 8)) begin
                    errors++;
                    $display("FAIL b2b f=%0d pos %0d: got data=%0d ptr=%0d last=%b, want data=%0d ptr=%0d",
                             f, k, gd[k], gp[k], gl[k], ed[k], ep[k]);
                end
            end
        end
    endtask

    task automatic test_n1;
        logic [7:0] val;
        int acc;
        int g;
        val = 8'($urandom);
        @(negedge clk);
        in_valid1 = 1'b1;
        in_data1  = val;
        descend   = 1'($urandom_range(1));
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_ready: got %b, want 1", in_ready1);
        end
        acc = cyc;
        @(negedge clk);
        in_valid1 = 1'b0;
        g = 0;
        while (out_valid1 !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== val || out_ptr1 !== 1'b0 || out_last1 !== 1'b1 || cyc - acc != 2) begin
            errors++;
            $display("FAIL n1_output: got vld=%b data=%0d ptr=%0d last=%b lat=%0d, want 1 %0d 0 1 2",
                     out_valid1, out_data1, out_ptr1, out_last1, cyc - acc, val);
        end
        @(negedge clk);
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_return: got out_valid=%b in_ready=%b, want 0 1", out_valid1, in_ready1);
        end
    endtask

    initial begin
        rst = 1'b1;
        descend = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        in_valid1 = 1'b0;
        in_data1 = '0;
        out_ready1 = 1'b1;
        test_reset();
        test_fixed(1'b0, 100, 1'b0);
        test_fixed(1'b1, 100, 1'b0);
        test_fixed(1'b0, 50, 1'b1);
        test_all_equal();
        test_random();
        test_reset_mid_sort();
        test_back_to_back();
        test_n1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
